// File: rtl/lenet_pkg.sv
// Shared types for the LeNet set controller: FSM states, phase encoding, watchdog default
// and the small decode helpers used by the controller.
package lenet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_CONV  = 3'd2,
    ST_FC1   = 3'd3,
    ST_FC2   = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_CONV = 2'd0,
    PH_FC1  = 2'd1,
    PH_FC2  = 2'd2,
    PH_NONE = 2'd3
  } phase_t;

  localparam int DEF_TIMEOUT_CYC = 60000;

  function automatic phase_t state_phase(input state_t st);
    phase_t ph;
    case (st)
      ST_CONV: ph = PH_CONV;
      ST_FC1:  ph = PH_FC1;
      ST_FC2:  ph = PH_FC2;
      default: ph = PH_NONE;
    endcase
    return ph;
  endfunction

  function automatic state_t state_after_phase(input state_t st);
    state_t nx;
    case (st)
      ST_CONV: nx = ST_FC1;
      ST_FC1:  nx = ST_FC2;
      ST_FC2:  nx = ST_NEXT;
      default: nx = ST_IDLE;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/lenet_done_collect.sv
// Per-lane done collector shared by the CONV/FC1/FC2 phases; accepts level or pulse done flags.
module lenet_done_collect #(
  parameter int NUM_SET = 2
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               clr,
  input  logic [NUM_SET-1:0] raw,
  output logic               all_done,
  output logic               skew
);

  logic [NUM_SET-1:0] seen_q;
  logic [NUM_SET-1:0] seen_d;
  logic [NUM_SET-1:0] seen_next_s;

  assign seen_next_s = seen_q | raw;
  assign all_done    = &seen_next_s;
  assign skew        = (|raw) & ~(&raw);

  // next sticky seen vector
  always_comb begin
    seen_d = seen_q;
    if (clr) begin
      seen_d = {NUM_SET{1'b0}};
    end else begin
      seen_d = seen_next_s;
    end
  end

  // seen register
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      seen_q <= {NUM_SET{1'b0}};
    end else begin
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/lenet_set_ctrl.sv
// Batch sequencer for NUM_SET lockstep LeNet cores with per-phase watchdog.
// Define LENET_LOCKSTEP_CHK_EN to enable the lane lockstep-skew check.
module lenet_set_ctrl
  import lenet_pkg::*;
#(
  parameter int NUM_SET     = 2,
  parameter int GROUP_W     = 8,
  parameter int TMO_W       = 16,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               batch_valid,
  output logic               batch_ready,
  input  logic [GROUP_W-1:0] batch_groups,
  input  logic               abort,
  output logic               conv_start,
  output logic [GROUP_W-1:0] group_idx,
  input  logic [NUM_SET-1:0] core_conv_done,
  input  logic [NUM_SET-1:0] core_fc1_done,
  input  logic [NUM_SET-1:0] core_fc2_done,
  output logic               busy,
  output logic               result_valid,
  output logic [GROUP_W-1:0] result_group,
  output logic               batch_done,
  output logic               err_timeout,
  output logic               err_mismatch
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [GROUP_W-1:0] groups_q, groups_d;
  logic [GROUP_W-1:0] idx_q, idx_d;
  logic [GROUP_W-1:0] res_grp_q;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               err_tmo_q, err_tmo_d;
  logic               err_mis_q, err_mis_d;
  logic               ready_q, start_q, busy_q, res_q, done_q;
  phase_t             phase_s;
  logic [NUM_SET-1:0] raw_s;
  logic               in_phase_s, clr_s, all_done_s, skew_s, mis_hit_s, last_grp_s;

  assign phase_s    = state_phase(state_q);
  assign in_phase_s = (phase_s != PH_NONE);
  assign last_grp_s = (idx_q == (groups_q - GROUP_W'(1)));
  assign clr_s      = abort | ~in_phase_s | (state_d != state_q);

  // done vector of the active phase only; other phases' flags are ignored
  always_comb begin
    raw_s = {NUM_SET{1'b0}};
    case (phase_s)
      PH_CONV: raw_s = core_conv_done;
      PH_FC1:  raw_s = core_fc1_done;
      PH_FC2:  raw_s = core_fc2_done;
      default: raw_s = {NUM_SET{1'b0}};
    endcase
  end

  lenet_done_collect #(.NUM_SET(NUM_SET)) u_collect (
    .clk      (clk),
    .srstn    (srstn),
    .clr      (clr_s),
    .raw      (raw_s),
    .all_done (all_done_s),
    .skew     (skew_s)
  );

`ifdef LENET_LOCKSTEP_CHK_EN
  assign mis_hit_s = in_phase_s & skew_s;
`else
  logic unused_skew_s;
  assign unused_skew_s = skew_s;
  assign mis_hit_s     = 1'b0;
`endif

  // next-state, group index and watchdog; abort overrides everything
  always_comb begin
    state_d   = state_q;
    groups_d  = groups_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    err_tmo_d = err_tmo_q;
    err_mis_d = err_mis_q;
    if (abort) begin
      state_d   = ST_IDLE;
      idx_d     = {GROUP_W{1'b0}};
      wdog_d    = {TMO_W{1'b0}};
      err_tmo_d = 1'b0;
      err_mis_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (batch_valid) begin
            groups_d = batch_groups;
            idx_d    = {GROUP_W{1'b0}};
            state_d  = (batch_groups == {GROUP_W{1'b0}}) ? ST_DONE : ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          wdog_d  = {TMO_W{1'b0}};
          state_d = ST_CONV;
        end
        ST_CONV, ST_FC1, ST_FC2: begin
          if (mis_hit_s) begin
            err_mis_d = 1'b1;
            state_d   = ST_ERR;
          end else if (all_done_s) begin
            wdog_d  = {TMO_W{1'b0}};
            state_d = state_after_phase(state_q);
          end else if (wdog_q == TMO_LAST) begin
            err_tmo_d = 1'b1;
            state_d   = ST_ERR;
          end else begin
            wdog_d = wdog_q + TMO_W'(1);
          end
        end
        ST_NEXT: begin
          if (last_grp_s) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + GROUP_W'(1);
            state_d = ST_START;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state, context and Moore outputs registered from the next state
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q   <= ST_IDLE;
      groups_q  <= {GROUP_W{1'b0}};
      idx_q     <= {GROUP_W{1'b0}};
      wdog_q    <= {TMO_W{1'b0}};
      err_tmo_q <= 1'b0;
      err_mis_q <= 1'b0;
      ready_q   <= 1'b1;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      res_q     <= 1'b0;
      res_grp_q <= {GROUP_W{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      groups_q  <= groups_d;
      idx_q     <= idx_d;
      wdog_q    <= wdog_d;
      err_tmo_q <= err_tmo_d;
      err_mis_q <= err_mis_d;
      ready_q   <= (state_d == ST_IDLE);
      start_q   <= (state_d == ST_START);
      busy_q    <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      res_q     <= (state_d == ST_NEXT);
      res_grp_q <= (state_d == ST_NEXT) ? idx_d : res_grp_q;
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign batch_ready  = ready_q;
  assign conv_start   = start_q;
  assign group_idx    = idx_q;
  assign busy         = busy_q;
  assign result_valid = res_q;
  assign result_group = res_grp_q;
  assign batch_done   = done_q;
  assign err_timeout  = err_tmo_q;
  assign err_mismatch = err_mis_q;

endmodule

// File: tb/tb_lenet_set_ctrl.sv
// Self-checking bench for lenet_set_ctrl: autonomous core models driven from conv_start,
// checked against a phase-timing reference model (completion = latest lane done time).
`timescale 1ns/1ps
module tb_lenet_set_ctrl;

  localparam int NUM_SET     = 2;
  localparam int GROUP_W     = 8;
  localparam int TMO_W       = 16;
  localparam int TIMEOUT_CYC = 20;
  localparam int MAXG        = 8;
  localparam int BIG         = 1 << 20;

  logic               clk = 1'b0;
  logic               srstn, batch_valid, abort;
  logic [GROUP_W-1:0] batch_groups;
  logic [NUM_SET-1:0] core_conv_done, core_fc1_done, core_fc2_done;
  logic               batch_ready, conv_start, busy, result_valid, batch_done;
  logic               err_timeout, err_mismatch;
  logic [GROUP_W-1:0] group_idx, result_group;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int dl [MAXG][NUM_SET][3];
  int conv_t [NUM_SET];
  int fc1_t  [NUM_SET];
  int fc2_t  [NUM_SET];
  bit hold_mode = 1'b0;
  bit noise     = 1'b0;

  int obs_start[$], obs_gidx[$], obs_res_t[$], obs_res_g[$], obs_done[$];
  int exp_start[$], exp_res[$];
  int exp_done;
  int busy_cnt, busy_first, tmo_first, mis_first;

  lenet_set_ctrl #(
    .NUM_SET(NUM_SET), .GROUP_W(GROUP_W), .TMO_W(TMO_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .srstn(srstn), .batch_valid(batch_valid), .batch_ready(batch_ready),
    .batch_groups(batch_groups), .abort(abort), .conv_start(conv_start), .group_idx(group_idx),
    .core_conv_done(core_conv_done), .core_fc1_done(core_fc1_done), .core_fc2_done(core_fc2_done),
    .busy(busy), .result_valid(result_valid), .result_group(result_group),
    .batch_done(batch_done), .err_timeout(err_timeout), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got time %0t required finish earlier", $time);
    $fatal(1, "simulation time bound exceeded");
  end

  task automatic set_delays(input int g, input int lane, input int a, input int b, input int c);
    dl[g][lane][0] = a;
    dl[g][lane][1] = b;
    dl[g][lane][2] = c;
  endtask

  task automatic clear_obs();
    obs_start.delete(); obs_gidx.delete(); obs_res_t.delete(); obs_res_g.delete(); obs_done.delete();
    busy_cnt = 0; busy_first = -1; tmo_first = -1; mis_first = -1;
  endtask

  task automatic clear_sched();
    for (int l = 0; l < NUM_SET; l++) begin
      conv_t[l] = BIG; fc1_t[l] = BIG; fc2_t[l] = BIG;
    end
    core_conv_done = '0; core_fc1_done = '0; core_fc2_done = '0;
  endtask

  task automatic drive_done();
    for (int l = 0; l < NUM_SET; l++) begin
      core_conv_done[l] = hold_mode ? (cyc >= conv_t[l]) : (cyc == conv_t[l]);
      core_fc1_done[l]  = hold_mode ? (cyc >= fc1_t[l])  : (cyc == fc1_t[l]);
      core_fc2_done[l]  = hold_mode ? (cyc >= fc2_t[l])  : (cyc == fc2_t[l]);
    end
  endtask

  // one negedge per cycle: sample outputs, react like the cores would, drive inputs
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      batch_valid = 1'b0;
      abort       = 1'b0;
      if (noise && !batch_ready && ($urandom_range(0, 3) == 0)) begin
        batch_valid  = 1'b1;
        batch_groups = GROUP_W'($urandom_range(1, 3));
      end
      if (conv_start) begin
        int g;
        g = obs_start.size();
        obs_start.push_back(cyc);
        obs_gidx.push_back(int'(group_idx));
        if (g < MAXG) begin
          for (int l = 0; l < NUM_SET; l++) begin
            conv_t[l] = cyc + dl[g][l][0];
            fc1_t[l]  = conv_t[l] + dl[g][l][1];
            fc2_t[l]  = fc1_t[l] + dl[g][l][2];
          end
        end
      end
      if (result_valid) begin
        obs_res_t.push_back(cyc);
        obs_res_g.push_back(int'(result_group));
      end
      if (batch_done) obs_done.push_back(cyc);
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
      end
      if (err_timeout && tmo_first < 0) tmo_first = cyc;
      if (err_mismatch && mis_first < 0) mis_first = cyc;
      drive_done();
    end
  endtask

  task automatic start_job(input int g, output int t);
    @(negedge clk);
    clear_obs();
    clear_sched();
    abort = 1'b0;
    n_checks++;
    if (batch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_job: got %b required 1", batch_ready);
    end
    batch_valid  = 1'b1;
    batch_groups = GROUP_W'(g);
    t = cyc;
  endtask

  // each phase ends at the latest lane's done time; 2 overhead cycles per group
  task automatic build_expect(input int t, input int g);
    int s, tmax, cum [NUM_SET];
    exp_start.delete();
    exp_res.delete();
    s = t + 1;
    for (int gi = 0; gi < g; gi++) begin
      exp_start.push_back(s);
      for (int l = 0; l < NUM_SET; l++) cum[l] = 0;
      tmax = s;
      for (int p = 0; p < 3; p++) begin
        tmax = 0;
        for (int l = 0; l < NUM_SET; l++) begin
          cum[l] += dl[gi][l][p];
          if (s + cum[l] > tmax) tmax = s + cum[l];
        end
      end
      exp_res.push_back(tmax + 1);
      s = tmax + 2;
    end
    exp_done = (g == 0) ? t + 1 : s;
  endtask

  task automatic run_batch(input int g, input string tag);
    int t;
    start_job(g, t);
    build_expect(t, g);
    run_cycles(exp_done + 1 - t);
    n_checks++;
    if (obs_start.size() != g) begin
      n_fail++;
      $display("FAIL %s start_count: got %0d required %0d", tag, obs_start.size(), g);
    end
    for (int i = 0; i < g && i < obs_start.size(); i++) begin
      n_checks += 2;
      if (obs_start[i] != exp_start[i]) begin
        n_fail++;
        $display("FAIL %s start_cycle[%0d]: got %0d required %0d", tag, i, obs_start[i] - t, exp_start[i] - t);
      end
      if (obs_gidx[i] != i) begin
        n_fail++;
        $display("FAIL %s group_idx[%0d]: got %0d required %0d", tag, i, obs_gidx[i], i);
      end
    end
    n_checks++;
    if (obs_res_t.size() != g) begin
      n_fail++;
      $display("FAIL %s result_count: got %0d required %0d", tag, obs_res_t.size(), g);
    end
    for (int i = 0; i < g && i < obs_res_t.size(); i++) begin
      n_checks += 2;
      if (obs_res_t[i] != exp_res[i]) begin
        n_fail++;
        $display("FAIL %s result_cycle[%0d]: got %0d required %0d", tag, i, obs_res_t[i] - t, exp_res[i] - t);
      end
      if (obs_res_g[i] != i) begin
        n_fail++;
        $display("FAIL %s result_group[%0d]: got %0d required %0d", tag, i, obs_res_g[i], i);
      end
    end
    n_checks++;
    if (obs_done.size() != 1 || obs_done[0] != exp_done) begin
      n_fail++;
      $display("FAIL %s batch_done: got count %0d first %0d required count 1 at %0d", tag,
               obs_done.size(), (obs_done.size() > 0) ? obs_done[0] - t : -1, exp_done - t);
    end
    n_checks++;
    if (busy_cnt != exp_done - t - 1 || (g > 0 && busy_first != t + 1)) begin
      n_fail++;
      $display("FAIL %s busy_window: got %0d cycles from %0d required %0d from %0d", tag,
               busy_cnt, busy_first - t, exp_done - t - 1, 1);
    end
    n_checks++;
    if (batch_ready !== 1'b1 || err_timeout !== 1'b0 || err_mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_state: got ready=%b tmo=%b mis=%b required 1 0 0", tag,
               batch_ready, err_timeout, err_mismatch);
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0; batch_valid = 1'b0; abort = 1'b0; batch_groups = '0;
    clear_sched();
    @(negedge clk);
    n_checks++;
    if ({batch_ready, conv_start, busy, result_valid, batch_done, err_timeout, err_mismatch} !== 7'b1000000
        || group_idx !== '0 || result_group !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b st=%b busy=%b rv=%b bd=%b tmo=%b mis=%b gi=%0d rg=%0d required 1 0 0 0 0 0 0 0 0",
               batch_ready, conv_start, busy, result_valid, batch_done, err_timeout, err_mismatch, group_idx, result_group);
    end
    @(negedge clk);
    srstn = 1'b1;
  endtask

  task automatic test_two_group();
    hold_mode = 1'b0; noise = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int l = 0; l < NUM_SET; l++) set_delays(g, l, 6, 6, 6);
    run_batch(2, "two_group");
  endtask

  task automatic test_empty();
    run_batch(0, "empty");
  endtask

  task automatic test_stale_done();
    hold_mode = 1'b1;
    for (int l = 0; l < NUM_SET; l++) set_delays(0, l, 2, 7, 3);
    run_batch(1, "stale_done");
    hold_mode = 1'b0;
  endtask

  task automatic test_timeout_edge();
    for (int l = 0; l < NUM_SET; l++) set_delays(0, l, TIMEOUT_CYC, 1, 1);
    run_batch(1, "timeout_edge");
  endtask

  task automatic test_skew();
    set_delays(0, 0, 2, 2, 8);
    set_delays(0, 1, 2, 5, 5);
`ifdef LENET_LOCKSTEP_CHK_EN
    begin
      int t;
      start_job(1, t);
      run_cycles(10);
      n_checks++;
      if (mis_first != t + 6 || obs_res_t.size() != 0 || busy !== 1'b1 || batch_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL skew_mismatch: got err at %0d results %0d busy %b ready %b required 6 0 1 0",
                 mis_first - t, obs_res_t.size(), busy, batch_ready);
      end
      abort = 1'b1;
      run_cycles(1);
      n_checks++;
      if (batch_ready !== 1'b1 || err_mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL skew_abort: got ready=%b mis=%b required 1 0", batch_ready, err_mismatch);
      end
    end
`else
    run_batch(1, "skew_tolerated");
`endif
  endtask

  task automatic test_watchdog();
    int t;
    noise = 1'b0;
    for (int l = 0; l < NUM_SET; l++) set_delays(0, l, 2, 2, BIG);
    start_job(1, t);
    run_cycles(30);
    n_checks++;
    if (tmo_first != t + 6 + TIMEOUT_CYC) begin
      n_fail++;
      $display("FAIL watchdog_cycle: got %0d required %0d", tmo_first - t, 6 + TIMEOUT_CYC);
    end
    n_checks++;
    if (busy !== 1'b1 || batch_ready !== 1'b0 || obs_res_t.size() != 0 || obs_done.size() != 0) begin
      n_fail++;
      $display("FAIL watchdog_err_state: got busy=%b ready=%b res=%0d done=%0d required 1 0 0 0",
               busy, batch_ready, obs_res_t.size(), obs_done.size());
    end
    abort = 1'b1;
    run_cycles(1);
    n_checks++;
    if (batch_ready !== 1'b1 || err_timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_abort: got ready=%b tmo=%b busy=%b required 1 0 0", batch_ready, err_timeout, busy);
    end
  endtask

  task automatic test_abort_vs_valid();
    @(negedge clk);
    clear_obs();
    clear_sched();
    batch_valid = 1'b1; batch_groups = GROUP_W'(2); abort = 1'b1;
    run_cycles(4);
    n_checks++;
    if (obs_start.size() != 0 || obs_done.size() != 0 || busy_cnt != 0 || batch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_wins: got starts=%0d dones=%0d busy=%0d ready=%b required 0 0 0 1",
               obs_start.size(), obs_done.size(), busy_cnt, batch_ready);
    end
  endtask

  task automatic test_reset_mid();
    int t, target;
    for (int g = 0; g < 4; g++)
      for (int l = 0; l < NUM_SET; l++) set_delays(g, l, 3, 4, 3);
    start_job(4, t);
    build_expect(t, 4);
    target = exp_start[1] + 3 + 2;
    run_cycles(target - t);
    srstn = 1'b0;
    #1;
    n_checks++;
    if ({batch_ready, conv_start, busy, result_valid, batch_done, err_timeout, err_mismatch} !== 7'b1000000
        || group_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rdy=%b st=%b busy=%b rv=%b bd=%b tmo=%b mis=%b gi=%0d required 1 0 0 0 0 0 0 0",
               batch_ready, conv_start, busy, result_valid, batch_done, err_timeout, err_mismatch, group_idx);
    end
    clear_obs();
    clear_sched();
    run_cycles(2);
    srstn = 1'b1;
    run_cycles(5);
    n_checks++;
    if (obs_res_t.size() != 0 || obs_done.size() != 0 || obs_start.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_discard: got res=%0d done=%0d starts=%0d required 0 0 0",
               obs_res_t.size(), obs_done.size(), obs_start.size());
    end
    for (int l = 0; l < NUM_SET; l++) set_delays(0, l, 2, 3, 4);
    run_batch(1, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int g;
      g = $urandom_range(1, 4);
      for (int gi = 0; gi < g; gi++)
        for (int p = 0; p < 3; p++) begin
          int d;
          d = $urandom_range(1, 8);
          for (int l = 0; l < NUM_SET; l++) dl[gi][l][p] = d;
        end
      hold_mode = bit'($urandom_range(0, 1));
      noise     = 1'b1;
      run_batch(g, "random");
    end
    hold_mode = 1'b0;
    noise     = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_group();
    test_empty();
    test_stale_done();
    test_timeout_edge();
    test_skew();
    test_watchdog();
    test_abort_vs_valid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
